// File: rtl/redmule_stream_arbiter.sv
// Arbitrates the X/W/Y source streams and the Z sink onto one shared memory port.
// Winner IDs are queued in order so each response is routed back to its originator.
module redmule_stream_arbiter #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned ZIdx      = 3,
  parameter int unsigned MaxOutst  = 4,
  parameter int unsigned StarveMax = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      z_priority_i,
  input  logic [NumReq-1:0]         req_i,
  output logic [NumReq-1:0]         gnt_o,
  output logic [$clog2(NumReq)-1:0] sel_o,
  output logic                      mem_req_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  output logic [NumReq-1:0]         rvalid_o,
  output logic [$clog2(NumReq)-1:0] rsel_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int unsigned IdxW    = $clog2(NumReq);
  localparam int unsigned PtrW    = $clog2(MaxOutst);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned StarveW = $clog2(StarveMax) + 1;

  typedef logic [IdxW-1:0] idx_t;

  localparam idx_t              ZId        = idx_t'(ZIdx);
  localparam idx_t              LastId     = idx_t'(NumReq - 1);
  localparam logic [IdxW:0]     NumReqC    = (IdxW + 1)'(NumReq);
  localparam logic [CntW-1:0]   MaxOutstC  = CntW'(MaxOutst);
  localparam logic [StarveW-1:0] StarveMaxC = StarveW'(StarveMax);

  // Architectural state
  idx_t                rr_ptr_reg, rr_ptr_next;
  logic [StarveW-1:0]  starve_cnt_reg, starve_cnt_next;
  logic [PtrW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PtrW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CntW-1:0]     outst_cnt_reg, outst_cnt_next;
  logic                err_reg, err_next;
  idx_t                id_fifo_reg [MaxOutst];

  // Combinational arbitration and bookkeeping
  logic [2*NumReq-1:0] req_dbl;
  logic [NumReq-1:0]   req_rot;
  logic [NumReq-1:0]   others_mask;
  idx_t                rr_off;
  logic [IdxW:0]       rr_sum;
  idx_t                rr_winner;
  idx_t                winner;
  idx_t                head_id;
  logic                starved;
  logic                z_pri_win;
  logic                others_req;
  logic                fifo_full;
  logic                fifo_empty;
  logic                handshake;
  logic                push;
  logic                pop;
  logic                stray_rsp;

  assign starved   = (starve_cnt_reg == StarveMaxC);
  assign z_pri_win = z_priority_i && req_i[ZIdx] && !starved;

  always_comb begin
    others_mask       = req_i;
    others_mask[ZIdx] = 1'b0;
  end
  assign others_req = |others_mask;

  // Rotate the doubled request vector so bit 0 is the requester at rr_ptr.
  assign req_dbl = {req_i, req_i};
  assign req_rot = NumReq'(req_dbl >> rr_ptr_reg);

  always_comb begin
    rr_off = '0;
    for (int k = int'(NumReq) - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        rr_off = idx_t'(k);
      end
    end
  end

  assign rr_sum    = {1'b0, rr_ptr_reg} + {1'b0, rr_off};
  assign rr_winner = (rr_sum >= NumReqC) ? idx_t'(rr_sum - NumReqC) : idx_t'(rr_sum);
  assign winner    = z_pri_win ? ZId : rr_winner;

  assign fifo_full  = (outst_cnt_reg == MaxOutstC);
  assign fifo_empty = (outst_cnt_reg == '0);

  assign mem_req_o = (|req_i) && !fifo_full;
  assign handshake = mem_req_o && mem_gnt_i;
  assign push      = handshake;
  assign pop       = mem_rvalid_i && !fifo_empty;
  assign stray_rsp = mem_rvalid_i && fifo_empty;

  assign head_id = id_fifo_reg[rd_ptr_reg];

  assign sel_o  = winner;
  assign rsel_o = fifo_empty ? '0 : head_id;
  assign busy_o = !fifo_empty;
  assign err_o  = err_reg;

  generate
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_route
      assign gnt_o[gi]    = handshake && (winner == idx_t'(gi));
      assign rvalid_o[gi] = pop && (head_id == idx_t'(gi));
    end
  endgenerate

  always_comb begin
    rr_ptr_next     = rr_ptr_reg;
    starve_cnt_next = starve_cnt_reg;
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    outst_cnt_next  = outst_cnt_reg;
    err_next        = err_reg | stray_rsp;

    if (handshake) begin
      rr_ptr_next = (winner == LastId) ? '0 : winner + 1'b1;
    end

    // Z-priority wins only count as starvation while someone else is waiting.
    if (!others_req) begin
      starve_cnt_next = '0;
    end else if (handshake && z_pri_win) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end else if (handshake && (winner != ZId)) begin
      starve_cnt_next = '0;
    end

    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end

    case ({push, pop})
      2'b10:   outst_cnt_next = outst_cnt_reg + 1'b1;
      2'b01:   outst_cnt_next = outst_cnt_reg - 1'b1;
      default: outst_cnt_next = outst_cnt_reg;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      rr_ptr_reg     <= '0;
      starve_cnt_reg <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      outst_cnt_reg  <= '0;
      err_reg        <= 1'b0;
    end else begin
      rr_ptr_reg     <= rr_ptr_next;
      starve_cnt_reg <= starve_cnt_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      outst_cnt_reg  <= outst_cnt_next;
      err_reg        <= err_next;
    end
  end

  // ID storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_fifo_reg[wr_ptr_reg] <= winner;
    end
  end

endmodule

// File: tb/tb_redmule_stream_arbiter.sv
// Directed bench for redmule_stream_arbiter: a queue-based reference model checked
// every cycle, plus literal expectations for the key arbitration scenarios.
module tb_redmule_stream_arbiter;

  localparam int N      = 4;
  localparam int Z      = 3;
  localparam int MAXO   = 4;
  localparam int STARVE = 8;

  logic       clk = 1'b0;
  logic       rst_n, clr, zp, mg, rv;
  logic [3:0] req;
  logic [3:0] gnt, rvalid;
  logic [1:0] sel, rsel;
  logic       mreq, busy, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  redmule_stream_arbiter #(
    .NumReq(N), .ZIdx(Z), .MaxOutst(MAXO), .StarveMax(STARVE)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .z_priority_i(zp),
    .req_i(req), .gnt_o(gnt), .sel_o(sel), .mem_req_o(mreq),
    .mem_gnt_i(mg), .mem_rvalid_i(rv), .rvalid_o(rvalid), .rsel_o(rsel),
    .busy_o(busy), .err_o(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: round-robin pointer, starvation count, in-order ID queue, sticky error.
  int m_rr, m_starve, n_rr, n_starve;
  int m_q[$];
  int n_q[$];
  bit m_err, n_err;
  bit m_valid = 1'b0;

  always @(negedge clk) begin
    int         win;
    bit         pri, others, mq, hs, pop;
    logic [3:0] e_gnt, e_rv;
    int         e_rsel;
    if (m_valid) begin
      others = (req & ~(4'b0001 << Z)) != 4'b0000;
      pri    = zp && req[Z] && (m_starve != STARVE);
      if (pri) begin
        win = Z;
      end else begin
        win = m_rr;
        for (int k = N - 1; k >= 0; k--)
          if (req[(m_rr + k) % N]) win = (m_rr + k) % N;
      end
      mq     = (req != 4'b0000) && (m_q.size() < MAXO);
      hs     = mq && mg;
      e_gnt  = hs ? 4'(1 << win) : 4'b0000;
      pop    = rv && (m_q.size() != 0);
      e_rv   = pop ? 4'(1 << m_q[0]) : 4'b0000;
      e_rsel = (m_q.size() != 0) ? m_q[0] : 0;

      chk("gnt_o", gnt, e_gnt);
      chk("sel_o", sel, win);
      chk("mem_req_o", mreq, mq);
      chk("rvalid_o", rvalid, e_rv);
      chk("rsel_o", rsel, e_rsel);
      chk("busy_o", busy, m_q.size() != 0);
      chk("err_o", err, m_err);

      n_q      = m_q;
      n_rr     = m_rr;
      n_starve = m_starve;
      n_err    = m_err;
      if (pop) begin
        $display("rsp  t=%0t id=%0d", $time, m_q[0]);
        void'(n_q.pop_front());
      end
      if (hs) begin
        $display("txn  t=%0t id=%0d", $time, win);
        n_q.push_back(win);
        n_rr = (win + 1) % N;
      end
      if (!others) n_starve = 0;
      else if (hs && pri) n_starve = m_starve + 1;
      else if (hs && win != Z) n_starve = 0;
      if (rv && m_q.size() == 0) n_err = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!rst_n || clr) begin
      m_rr = 0; m_starve = 0; m_q.delete(); m_err = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_rr = n_rr; m_starve = n_starve; m_q = n_q; m_err = n_err;
    end
  end

  task automatic drive(input logic r_n, input logic c, input logic z,
                       input logic [3:0] r, input logic g, input logic v);
    @(posedge clk);
    #1;
    rst_n = r_n; clr = c; zp = z; req = r; mg = g; rv = v;
    #3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_g [6];
    int hs_cnt;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100};
    rst_n = 1'b0; clr = 1'b0; zp = 1'b0; req = 4'b0; mg = 1'b0; rv = 1'b0;

    // Reset state with no requests
    drive(0, 0, 0, 4'b0000, 0, 0);
    drive(0, 0, 0, 4'b0000, 0, 0);
    drive(1, 0, 0, 4'b0000, 0, 0);
    chk("rst_gnt", gnt, 0);   chk("rst_sel", sel, 0);   chk("rst_mreq", mreq, 0);
    chk("rst_rvalid", rvalid, 0); chk("rst_rsel", rsel, 0);
    chk("rst_busy", busy, 0); chk("rst_err", err, 0);

    // Plain round robin over X/W/Y with responses one cycle later
    drive(1, 0, 0, 4'b0111, 1, 0);
    chk("rr_gnt", gnt, exp_g[0]);
    for (int i = 1; i < 6; i++) begin
      drive(1, 0, 0, 4'b0111, 1, 1);
      chk("rr_gnt", gnt, exp_g[i]);
      chk("rr_rvalid", rvalid, exp_g[i-1]);
    end
    drive(1, 0, 0, 4'b0000, 0, 1);
    chk("rr_rvalid_last", rvalid, 4'b0100);
    drive(1, 0, 0, 4'b0000, 0, 0);
    chk("rr_idle_busy", busy, 0);

    // Z priority with starvation relief after StarveMax grants
    drive(0, 0, 0, 4'b0000, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 1, 4'b1111, 1, (i > 0));
      chk("zpri_gnt", gnt, (i == 8) ? 4'b0001 : 4'b1000);
    end
    drive(1, 0, 0, 4'b0000, 0, 1);
    drive(1, 0, 0, 4'b0000, 0, 0);
    chk("zpri_drained", busy, 0);

    // Outstanding limit: four handshakes, then blocked until a response returns
    drive(0, 0, 0, 4'b0000, 0, 0);
    hs_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 4'b0111, 1, 0);
      if (gnt != 4'b0000) hs_cnt++;
    end
    chk("full_hs_count", hs_cnt, 4);
    chk("full_mreq", mreq, 0);
    chk("full_busy", busy, 1);
    drive(1, 0, 0, 4'b0111, 1, 1);
    chk("full_blocked_gnt", gnt, 4'b0000);
    chk("full_rvalid", rvalid, 4'b0001);
    drive(1, 0, 0, 4'b0111, 1, 0);
    chk("full_one_more", gnt, 4'b0010);
    drive(1, 0, 0, 4'b0111, 1, 0);
    chk("full_again_gnt", gnt, 4'b0000);
    chk("full_again_mreq", mreq, 0);

    // Reset with three outstanding, then a stray response and a Z request
    drive(0, 0, 0, 4'b0000, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 4'b0111, 1, 0);
    drive(1, 0, 0, 4'b0000, 0, 0);
    chk("mid_busy", busy, 1);
    drive(0, 0, 0, 4'b0000, 0, 0);
    drive(1, 0, 0, 4'b0000, 0, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sel", sel, 0);
    drive(1, 0, 0, 4'b0000, 0, 1);
    chk("mid_stray_rvalid", rvalid, 0);
    drive(1, 0, 0, 4'b1000, 1, 0);
    chk("mid_stray_err", err, 1);
    chk("mid_z_gnt", gnt, 4'b1000);
    drive(1, 0, 0, 4'b0000, 0, 1);
    chk("mid_z_rvalid", rvalid, 4'b1000);

    // Sticky error held until a soft clear
    drive(0, 0, 0, 4'b0000, 0, 0);
    drive(1, 0, 0, 4'b0000, 0, 1);
    chk("err_pre", err, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 4'b0000, 0, 0);
      chk("err_hold", err, 1);
    end
    drive(1, 1, 0, 4'b0000, 0, 0);
    chk("err_clear_cycle", err, 1);
    drive(1, 0, 0, 4'b0000, 0, 0);
    chk("err_cleared", err, 0);

    drive(1, 0, 0, 4'b0000, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
